keypad_time_entry: RTL and testbench
====================================

# keypad_time_entry

Registers keypad digits for the microwave cook-time display. Sits directly downstream of the keypad decimal-to-BCD encoder and consumes its 4-bit BCD digit and its high-true "key valid" flag (`loadn`). Each debounced keypress shifts one digit into a 4-digit MM:SS register from the right, like a microwave keypad. The result feeds the countdown timer and the display decoders.

## Interface
- `DEBOUNCE_CYCLES`, 4, consecutive synchronized samples required to accept a press and a release (≥1)
- `CNT_W`, 4, debounce counter width; must hold DEBOUNCE_CYCLES
- `clk`  in  1  system clock
- `clearn`  in  1  reset, asynchronous, active-low
- `digit`  in  4  BCD digit from encoder `y`
- `loadn`  in  1  encoder data-valid; 1 = key held with a valid code
- `enable_n`  in  1  0 = entry permitted; 1 = presses are consumed but not stored (cooking in progress)
- `clear`  in  1  synchronous clear of the entered time
- `sec_ones`, `sec_tens`, `min_ones`, `min_tens`  out  4 each  entered digits
- `digit_count`  out  3  digits stored, 0..4
- `full`  out  1  `digit_count == 4`
- `digit_strobe`  out  1  one-cycle pulse: a digit was stored
- `reject`  out  1  one-cycle pulse: a press was accepted but not stored
- `time_valid`  out  1  `digit_count != 0` and `sec_tens <= 5` (combinational from registers)

## Operation
- `loadn` and `digit` each pass through the same 2-flop synchronizer: `loadn_s` and `digit_s`. This keeps them aligned.
- FSM states: IDLE, PRESS, CAPTURE, HOLD.
  - IDLE: if `loadn_s` = 1, go to PRESS with cnt = 1.
  - PRESS: if `loadn_s` = 0, return to IDLE with cnt = 0. Otherwise cnt++. When cnt + 1 == DEBOUNCE_CYCLES, go to CAPTURE. With DEBOUNCE_CYCLES = 1, go from IDLE directly to CAPTURE.
  - CAPTURE: evaluate for one cycle, then go to HOLD with cnt = 0.
  - HOLD: count consecutive `loadn_s` = 0 samples; any 1 resets cnt. After DEBOUNCE_CYCLES low samples, go to IDLE.
- CAPTURE store condition: `enable_n` = 0, `digit_s` <= 9, and not `full`.
  - Store: `min_tens`←`min_ones`, `min_ones`←`sec_tens`, `sec_tens`←`sec_ones`, `sec_ones`←`digit_s`. `digit_count` increments and `digit_strobe` = 1.
  - Otherwise no register changes and `reject` = 1.
- `clear` = 1 at an edge sets all digits, `digit_count`, and cnt to 0, and forces the FSM to HOLD. A key still held must be released before the next press counts.
- `clear` has priority over CAPTURE: no store, no strobe, no reject.
- `digit_count` saturates at 4. Digits never wrap or drop; a 5th press is rejected.
- BCD range is enforced only on the digit value. MM:SS range is reported via `time_valid`, not corrected.

## Timing
- Async reset (`clearn` = 0):
  - all digits 0, `digit_count` 0, `full` 0, `time_valid` 0
  - `digit_strobe` 0, `reject` 0
  - synchronizer flops 0, FSM IDLE, cnt 0
- Reset applied mid-press: the press is lost. After release of `clearn`, a still-held key is re-debounced from IDLE.
- Latency, counting the first edge sampling `loadn` = 1 as edge 1: `loadn_s` = 1 after edge 2. Digit registers and `digit_strobe`/`reject` update at edge DEBOUNCE_CYCLES + 3, which is edge 7 for the default.
- `digit_strobe` and `reject` are registered, high for exactly one cycle, and mutually exclusive.
- `digit_s` is sampled at the CAPTURE cycle. The encoder must hold `digit` stable while `loadn` = 1.
- Minimum press-to-press spacing: DEBOUNCE_CYCLES low samples in HOLD + 2 synchronizer cycles + the next press debounce.
- `enable_n` and `clear` are sampled synchronously; their only effects are the ones above.

## Test plan
- Reset, then press `digit`=1 with `loadn` held 10 cycles, release 10 cycles → `sec_ones`=1, `digit_count`=1, `digit_strobe` pulse at edge 7, exactly one pulse.
- Keys 1,2,3,0 in sequence → `min_tens`=1, `min_ones`=2, `sec_tens`=3, `sec_ones`=0, `full`=1, `time_valid`=1. A 5th key 7 → `reject` pulse, registers unchanged.
- `loadn` bounce: pulses of 2 high / 1 low cycles for 12 cycles, then steady high → exactly one store. Bounces during release → no second store.
- Keys 0,9,0 → `sec_tens`=9, `time_valid`=0. `digit`=4'hC with `loadn`=1 → `reject`, no shift.
- `enable_n`=1 with key 5 → `reject`, `digit_count` unchanged. `clear` asserted during PRESS while the key is held → all zero, and no store until the key is released and pressed again.
- Assert `clearn`=0 mid-PRESS → all outputs 0 immediately. Release `clearn` with the key still held → store occurs DEBOUNCE_CYCLES+3 edges after release.

Source files
------------

// File: rtl/keypad_time_entry.sv
// Keypad digit entry for the microwave cook time: synchronizes and debounces the
// encoder's key-valid flag, then shifts each accepted BCD digit into an MM:SS register.
module keypad_time_entry #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 4
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic [3:0] digit,
  input  logic       loadn,
  input  logic       enable_n,
  input  logic       clear,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic [2:0] digit_count,
  output logic       full,
  output logic       digit_strobe,
  output logic       reject,
  output logic       time_valid
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_e;

  localparam logic [CNT_W:0] DEB_LAST = (CNT_W + 1)'(DEBOUNCE_CYCLES);

  logic             loadnMeta_q, loadnS_q;
  logic [3:0]       digitMeta_q, digitS_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cntInc;
  logic [3:0]       secOnes_q, secTens_q, minOnes_q, minTens_q;
  logic [2:0]       digitCount_q;
  logic             strobe_q, reject_q;
  logic             storeEn, rejectEn;

  // Digit and valid share one synchronizer so the captured digit lines up with its flag.
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      loadnMeta_q <= 1'b0;
      loadnS_q    <= 1'b0;
      digitMeta_q <= 4'd0;
      digitS_q    <= 4'd0;
    end else begin
      loadnMeta_q <= loadn;
      loadnS_q    <= loadnMeta_q;
      digitMeta_q <= digit;
      digitS_q    <= digitMeta_q;
    end
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cntInc = {1'b0, cnt_q} + 1'b1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    storeEn  = 1'b0;
    rejectEn = 1'b0;
    if (clear) begin
      state_d = HOLD;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (loadnS_q) begin
            if (DEB_LAST == 1) begin
              state_d = CAPTURE;
              cnt_d   = '0;
            end else begin
              state_d = PRESS;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        PRESS: begin
          if (!loadnS_q) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cntInc == DEB_LAST) begin
            state_d = CAPTURE;
            cnt_d   = '0;
          end else begin
            cnt_d = cntInc[CNT_W-1:0];
          end
        end
        CAPTURE: begin
          state_d = HOLD;
          cnt_d   = '0;
          if (!enable_n && (digitS_q <= 4'd9) && !full) begin
            storeEn = 1'b1;
          end else begin
            rejectEn = 1'b1;
          end
        end
        HOLD: begin
          // Any high sample restarts the release count, so bounce cannot end the hold early.
          if (loadnS_q) begin
            cnt_d = '0;
          end else if (cntInc == DEB_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cntInc[CNT_W-1:0];
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      secOnes_q    <= 4'd0;
      secTens_q    <= 4'd0;
      minOnes_q    <= 4'd0;
      minTens_q    <= 4'd0;
      digitCount_q <= 3'd0;
      strobe_q     <= 1'b0;
      reject_q     <= 1'b0;
    end else begin
      strobe_q <= storeEn;
      reject_q <= rejectEn;
      if (clear) begin
        secOnes_q    <= 4'd0;
        secTens_q    <= 4'd0;
        minOnes_q    <= 4'd0;
        minTens_q    <= 4'd0;
        digitCount_q <= 3'd0;
      end else if (storeEn) begin
        minTens_q    <= minOnes_q;
        minOnes_q    <= secTens_q;
        secTens_q    <= secOnes_q;
        secOnes_q    <= digitS_q;
        digitCount_q <= digitCount_q + 3'd1;
      end
    end
  end

  assign sec_ones     = secOnes_q;
  assign sec_tens     = secTens_q;
  assign min_ones     = minOnes_q;
  assign min_tens     = minTens_q;
  assign digit_count  = digitCount_q;
  assign full         = (digitCount_q == 3'd4);
  assign digit_strobe = strobe_q;
  assign reject       = reject_q;
  assign time_valid   = (digitCount_q != 3'd0) && (secTens_q <= 4'd5);

endmodule

// File: tb/tb_keypad_time_entry.sv
// Scoreboard bench for keypad_time_entry: stimulus pushes expected store/reject
// results, a negedge monitor pops and compares them whenever a pulse appears.
module tb_keypad_time_entry;

  logic       clk;
  logic       clearn;
  logic [3:0] digit;
  logic       loadn;
  logic       enable_n;
  logic       clear;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic [2:0] digit_count;
  logic       full, digit_strobe, reject, time_valid;

  typedef struct {
    logic        isStore;
    logic [15:0] digits;
    logic [2:0]  count;
  } exp_t;

  exp_t sbQ[$];
  exp_t monExp;
  int   checks = 0;
  int   errors = 0;

  keypad_time_entry dut (
    .clk          (clk),
    .clearn       (clearn),
    .digit        (digit),
    .loadn        (loadn),
    .enable_n     (enable_n),
    .clear        (clear),
    .sec_ones     (sec_ones),
    .sec_tens     (sec_tens),
    .min_ones     (min_ones),
    .min_tens     (min_tens),
    .digit_count  (digit_count),
    .full         (full),
    .digit_strobe (digit_strobe),
    .reject       (reject),
    .time_valid   (time_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic expectPulse(input logic isStore, input logic [15:0] digits, input logic [2:0] count);
    exp_t e;
    e.isStore = isStore;
    e.digits  = digits;
    e.count   = count;
    sbQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [3:0] d, input int highCycles, input int lowCycles);
    @(negedge clk);
    digit = d;
    loadn = 1'b1;
    repeat (highCycles) @(negedge clk);
    loadn = 1'b0;
    repeat (lowCycles) @(negedge clk);
  endtask

  task automatic pulseClear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_digits"}, {16'd0, min_tens, min_ones, sec_tens, sec_ones}, 32'd0);
    checkOutput({name, "_count"}, {29'd0, digit_count}, 32'd0);
    checkOutput({name, "_flags"}, {28'd0, full, time_valid, digit_strobe, reject}, 32'd0);
  endtask

  // Monitor: every store/reject pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (clearn && (digit_strobe || reject)) begin
      checkOutput("pulse_exclusive", {31'd0, digit_strobe && reject}, 32'd0);
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pulse: got strobe=%0b reject=%0b, expected no pulse", digit_strobe, reject);
      end else begin
        monExp = sbQ.pop_front();
        checkOutput("pulse_kind", {31'd0, digit_strobe}, {31'd0, monExp.isStore});
        checkOutput("pulse_digits", {16'd0, min_tens, min_ones, sec_tens, sec_ones}, {16'd0, monExp.digits});
        checkOutput("pulse_count", {29'd0, digit_count}, {29'd0, monExp.count});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearn   = 1'b0;
    digit    = 4'd0;
    loadn    = 1'b0;
    enable_n = 1'b0;
    clear    = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    clearn = 1'b1;
    repeat (3) @(negedge clk);

    // Single press with the store landing exactly on edge 7
    expectPulse(1'b1, 16'h0001, 3'd1);
    @(negedge clk);
    digit = 4'd1;
    loadn = 1'b1;
    repeat (6) @(posedge clk);
    #1 checkOutput("latency_edge6", {31'd0, digit_strobe}, 32'd0);
    @(posedge clk);
    #1 checkOutput("latency_edge7", {31'd0, digit_strobe}, 32'd1);
    repeat (3) @(negedge clk);
    loadn = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("t1_flags", {30'd0, full, time_valid}, 32'h1);

    // Fill to four digits, then a fifth press must be rejected
    pulseClear();
    checkAllZero("clear1");
    expectPulse(1'b1, 16'h0001, 3'd1);
    applyStimulus(4'd1, 10, 10);
    expectPulse(1'b1, 16'h0012, 3'd2);
    applyStimulus(4'd2, 10, 10);
    expectPulse(1'b1, 16'h0123, 3'd3);
    applyStimulus(4'd3, 10, 10);
    expectPulse(1'b1, 16'h1230, 3'd4);
    applyStimulus(4'd0, 10, 10);
    checkOutput("full_flags", {30'd0, full, time_valid}, 32'h3);
    expectPulse(1'b0, 16'h1230, 3'd4);
    applyStimulus(4'd7, 10, 10);

    // Bouncing press and release still yield exactly one store
    pulseClear();
    expectPulse(1'b1, 16'h0006, 3'd1);
    @(negedge clk);
    digit = 4'd6;
    for (int i = 0; i < 4; i++) begin
      loadn = 1'b1;
      repeat (2) @(negedge clk);
      loadn = 1'b0;
      @(negedge clk);
    end
    loadn = 1'b1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      loadn = 1'b0;
      repeat (2) @(negedge clk);
      loadn = 1'b1;
      @(negedge clk);
    end
    loadn = 1'b0;
    repeat (10) @(negedge clk);

    // Seconds tens of 9 is stored but flagged invalid; non-BCD code is rejected
    pulseClear();
    expectPulse(1'b1, 16'h0000, 3'd1);
    applyStimulus(4'd0, 10, 10);
    expectPulse(1'b1, 16'h0009, 3'd2);
    applyStimulus(4'd9, 10, 10);
    expectPulse(1'b1, 16'h0090, 3'd3);
    applyStimulus(4'd0, 10, 10);
    checkOutput("tens9_valid", {31'd0, time_valid}, 32'd0);
    expectPulse(1'b0, 16'h0090, 3'd3);
    applyStimulus(4'hC, 10, 10);

    // Entry disabled while cooking
    enable_n = 1'b1;
    expectPulse(1'b0, 16'h0090, 3'd3);
    applyStimulus(4'd5, 10, 10);
    enable_n = 1'b0;

    // Clear during a held press: nothing stored until release and a fresh press
    @(negedge clk);
    digit = 4'd2;
    loadn = 1'b1;
    repeat (4) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checkAllZero("clear_press");
    repeat (10) @(negedge clk);
    loadn = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("clear_press_count", {29'd0, digit_count}, 32'd0);
    expectPulse(1'b1, 16'h0002, 3'd1);
    applyStimulus(4'd2, 10, 10);

    // Async reset mid-press, key re-debounced after reset release
    @(negedge clk);
    digit = 4'd8;
    loadn = 1'b1;
    repeat (4) @(negedge clk);
    clearn = 1'b0;
    #1 checkAllZero("async_reset");
    repeat (3) @(negedge clk);
    expectPulse(1'b1, 16'h0008, 3'd1);
    clearn = 1'b1;
    repeat (6) @(posedge clk);
    #1 checkOutput("rst_latency_edge6", {31'd0, digit_strobe}, 32'd0);
    @(posedge clk);
    #1 checkOutput("rst_latency_edge7", {31'd0, digit_strobe}, 32'd1);
    repeat (3) @(negedge clk);
    loadn = 1'b0;
    repeat (20) @(negedge clk);

    checkOutput("scoreboard_drained", sbQ.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
